// File: rtl/newcond_evaluator_pkg.sv
// Shared types and constants for the exhaustive-sweep evaluator.
// The polynomial and init words are held wide; users slice to their SIG_W.
package newcond_evaluator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [31:0] CRC_POLY = 32'h0000_1021;
   localparam logic [31:0] SIG_INIT = 32'hFFFF_FFFF;

endpackage

// File: rtl/misr_step.sv
// One combinational MISR update: absorbs all N_OUT data bits, bit 0 first,
// one CRC shift per bit.
module misr_step
   import newcond_evaluator_pkg::*;
#(
   parameter int N_OUT = 2,
   parameter int SIG_W = 16
) (
   input  logic [SIG_W-1:0] sig,
   input  logic [N_OUT-1:0] data,
   output logic [SIG_W-1:0] sig_next
);

   logic fb;

   always_comb begin
      fb       = 1'b0;
      sig_next = sig;
      for (int i = 0; i < N_OUT; i++) begin
         fb       = sig_next[SIG_W-1] ^ data[i];
         sig_next = {sig_next[SIG_W-2:0], 1'b0} ^ (fb ? CRC_POLY[SIG_W-1:0] : '0);
      end
   end

endmodule

// File: rtl/newcond_evaluator.sv
// Drives every N_IN-bit vector into a combinational circuit, compares each
// response with a streamed golden word and compacts the responses in a MISR.
module newcond_evaluator
   import newcond_evaluator_pkg::*;
#(
   parameter int N_IN  = 11,
   parameter int N_OUT = 2,
   parameter int SIG_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic [N_IN-1:0]  pi,
   input  logic [N_OUT-1:0] po,
   input  logic             exp_valid,
   output logic             exp_ready,
   input  logic [N_OUT-1:0] exp_data,
   output logic             busy,
   output logic             done,
   output logic [N_IN:0]    mismatch_cnt,
   output logic [N_IN-1:0]  first_fail_vec,
   output logic             first_fail_valid,
   output logic [SIG_W-1:0] signature
);

   state_t           state;
   logic [SIG_W-1:0] sig_next;
   logic             hs;

   assign exp_ready = busy;
   assign hs        = exp_valid & exp_ready;

   misr_step #(
      .N_OUT(N_OUT),
      .SIG_W(SIG_W)
   ) u_misr (
      .sig     (signature),
      .data    (po),
      .sig_next(sig_next)
   );

   // Abort outranks a handshake; without a handshake every result holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         pi               <= '0;
         mismatch_cnt     <= '0;
         first_fail_vec   <= '0;
         first_fail_valid <= 1'b0;
         signature        <= SIG_INIT[SIG_W-1:0];
         busy             <= 1'b0;
         done             <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  pi               <= '0;
                  mismatch_cnt     <= '0;
                  first_fail_vec   <= '0;
                  first_fail_valid <= 1'b0;
                  signature        <= SIG_INIT[SIG_W-1:0];
                  busy             <= 1'b1;
                  state            <= DRIVE;
               end
            end
            DRIVE: begin
               if (abort) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else if (hs) begin
                  signature <= sig_next;
                  pi        <= pi + N_IN'(1);
                  if (po != exp_data) begin
                     mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                     if (!first_fail_valid) begin
                        first_fail_vec   <= pi;
                        first_fail_valid <= 1'b1;
                     end
                  end
                  if (&pi) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_newcond_evaluator.sv
// Scoreboard bench: each sweep pushes its expected results; a monitor pops
// and compares them on the done pulse and tracks every handshake.
module tb_newcond_evaluator;

   localparam int N_IN  = 11;
   localparam int N_OUT = 2;
   localparam int SIG_W = 16;

   typedef struct {
      logic [N_IN:0]    mm;
      logic [N_IN-1:0]  ffvec;
      logic             ffvalid;
      logic [SIG_W-1:0] sig;
   } res_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             abort;
   logic [N_IN-1:0]  pi;
   logic [N_OUT-1:0] po;
   logic             exp_valid;
   logic             exp_ready;
   logic [N_OUT-1:0] exp_data;
   logic             busy;
   logic             done;
   logic [N_IN:0]    mismatch_cnt;
   logic [N_IN-1:0]  first_fail_vec;
   logic             first_fail_valid;
   logic [SIG_W-1:0] signature;

   int checks     = 0;
   int failures   = 0;
   int fault_a    = -1;
   int fault_b    = -1;
   int done_count = 0;
   int hs_count   = 0;
   int gap_count  = 0;
   int last_hs    = 0;
   int last_gaps  = 0;
   logic [N_IN-1:0] exp_pi = '0;
   res_t sb_q[$];

   always #5 clk = ~clk;

   function automatic logic [1:0] stub(input logic [N_IN-1:0] v);
      return {v[3] ^ v[7], v[0] & v[10]};
   endfunction

   assign po       = stub(pi);
   assign exp_data = stub(pi) ^ {1'b0, (int'(pi) == fault_a) || (int'(pi) == fault_b)};

   newcond_evaluator #(
      .N_IN (N_IN),
      .N_OUT(N_OUT),
      .SIG_W(SIG_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .pi              (pi),
      .po              (po),
      .exp_valid       (exp_valid),
      .exp_ready       (exp_ready),
      .exp_data        (exp_data),
      .busy            (busy),
      .done            (done),
      .mismatch_cnt    (mismatch_cnt),
      .first_fail_vec  (first_fail_vec),
      .first_fail_valid(first_fail_valid),
      .signature       (signature)
   );

   // Expected results for vectors 0..last with golden corrupted at fa and fb.
   function automatic res_t model(input int last, input int fa, input int fb);
      res_t r;
      logic [1:0]  p;
      logic        fbit;
      r.mm      = '0;
      r.ffvec   = '0;
      r.ffvalid = 1'b0;
      r.sig     = 16'hFFFF;
      for (int v = 0; v <= last; v++) begin
         p = stub(v[N_IN-1:0]);
         for (int b = 0; b < 2; b++) begin
            fbit  = r.sig[15] ^ p[b];
            r.sig = r.sig << 1;
            if (fbit) r.sig = r.sig ^ 16'h1021;
         end
         if (v == fa || v == fb) begin
            r.mm = r.mm + 1;
            if (!r.ffvalid) begin
               r.ffvec   = v[N_IN-1:0];
               r.ffvalid = 1'b1;
            end
         end
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare on done, otherwise track handshake order and count.
   always @(negedge clk) begin
      res_t e;
      if (done) begin
         done_count++;
         last_hs   = hs_count;
         last_gaps = gap_count;
         checkOutput("done_expected", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput("sb_mismatch_cnt", 32'(mismatch_cnt), 32'(e.mm));
            checkOutput("sb_first_fail_vec", 32'(first_fail_vec), 32'(e.ffvec));
            checkOutput("sb_first_fail_valid", 32'(first_fail_valid), 32'(e.ffvalid));
            checkOutput("sb_signature", 32'(signature), 32'(e.sig));
         end
      end else if (!busy) begin
         hs_count  = 0;
         gap_count = 0;
         exp_pi    = '0;
      end else if (exp_valid && exp_ready) begin
         if (pi != exp_pi) gap_count++;
         exp_pi = exp_pi + 1'b1;
         hs_count++;
      end
   end

   task automatic start_sweep();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 0: continuous valid; 1: random 50% valid; 2: start pulses while busy
   task automatic applyStimulus(input int mode, input res_t exp, input string tag);
      int cyc;
      int done_cyc;
      int dc_before;
      dc_before = done_count;
      sb_q.push_back(exp);
      start_sweep();
      exp_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc       = 1;
      done_cyc  = -1;
      while (sb_q.size() != 0 && cyc < 20000) begin
         @(posedge clk); #1;
         cyc++;
         if (done && done_cyc < 0) done_cyc = cyc;
         exp_valid = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
         start     = (mode == 2) && (pi == 10 || pi == 2047);
      end
      start     = 1'b0;
      exp_valid = 1'b0;
      if (sb_q.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_timeout actual=no_done expected=done", tag);
         void'(sb_q.pop_front());
      end
      repeat (3) @(posedge clk);
      #1;
      checkOutput({tag, "_done_pulses"}, 32'(done_count - dc_before), 32'd1);
      checkOutput({tag, "_handshakes"}, 32'(last_hs), 32'd2048);
      checkOutput({tag, "_pi_gaps"}, 32'(last_gaps), 32'd0);
      if (mode != 1) checkOutput({tag, "_done_cycle"}, 32'(done_cyc), 32'd2049);
   endtask

   initial begin
      res_t clean;
      res_t r;
      int   dc;
      int   guard;
      rst       = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      exp_valid = 1'b0;
      #3 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_pi", 32'(pi), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_exp_ready", 32'(exp_ready), 32'd0);
      checkOutput("rst_signature", 32'(signature), 32'hFFFF);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("idle_after_rst", 32'(busy), 32'd0);

      clean = model(2047, -1, -1);
      applyStimulus(0, clean, "clean");

      fault_a = 'h155;
      fault_b = 'h6A0;
      applyStimulus(0, model(2047, fault_a, fault_b), "fault");
      fault_a = -1;
      fault_b = -1;

      applyStimulus(1, clean, "backpressure");
      applyStimulus(2, clean, "start_busy");

      // Abort lands on the handshake of vector 100, which is also corrupted.
      fault_a = 50;
      fault_b = 100;
      r  = model(99, fault_a, fault_b);
      dc = done_count;
      start_sweep();
      exp_valid = 1'b1;
      guard = 0;
      while (pi != 100 && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_pi", 32'(pi), 32'd100);
      checkOutput("abort_mismatch_cnt", 32'(mismatch_cnt), 32'(r.mm));
      checkOutput("abort_first_fail_vec", 32'(first_fail_vec), 32'(r.ffvec));
      checkOutput("abort_signature", 32'(signature), 32'(r.sig));
      repeat (4) @(posedge clk);
      #1;
      checkOutput("abort_no_done", 32'(done_count - dc), 32'd0);
      checkOutput("abort_hold_cnt", 32'(mismatch_cnt), 32'(r.mm));
      exp_valid = 1'b0;

      // Asynchronous reset in the middle of vector 500.
      fault_a = 'h155;
      fault_b = -1;
      dc = done_count;
      start_sweep();
      exp_valid = 1'b1;
      guard = 0;
      while (pi != 500 && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_pi", 32'(pi), 32'd0);
      checkOutput("midrst_mismatch_cnt", 32'(mismatch_cnt), 32'd0);
      checkOutput("midrst_first_fail_vec", 32'(first_fail_vec), 32'd0);
      checkOutput("midrst_first_fail_valid", 32'(first_fail_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_exp_ready", 32'(exp_ready), 32'd0);
      checkOutput("midrst_signature", 32'(signature), 32'hFFFF);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midrst_stay_idle", 32'(busy), 32'd0);
      checkOutput("midrst_no_done", 32'(done_count - dc), 32'd0);
      exp_valid = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/newcond_evaluator.md
NEWCOND_EVALUATOR -- requirements
Module: newcond_evaluator

Interface
REQ-001 SHALL have parameter N_IN, default 11, giving the width of the vector driven to the circuit under evaluation.
REQ-002 SHALL have parameter N_OUT, default 2, giving the width of the response read back.
REQ-003 SHALL have parameter SIG_W, default 16, giving the signature register width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  begin an exhaustive sweep (sampled in IDLE only).
REQ-008 abort  in  1  terminate the sweep and return to IDLE.
REQ-009 pi  out  N_IN  registered input vector to the circuit (combinational circuit, po valid in the same cycle).
REQ-010 po  in  N_OUT  circuit response to the current pi.
REQ-011 exp_valid  in  1  golden response word available.
REQ-012 exp_ready  out  1  evaluator accepts the golden word this cycle.
REQ-013 exp_data  in  N_OUT  golden response for the current pi.
REQ-014 busy  out  1  sweep in progress.
REQ-015 done  out  1  one-cycle pulse at sweep completion.
REQ-016 mismatch_cnt  out  N_IN+1  number of vectors with po != exp_data.
REQ-017 first_fail_vec  out  N_IN  pi value of the first mismatch.
REQ-018 first_fail_valid  out  1  first_fail_vec holds a captured value.
REQ-019 signature  out  SIG_W  MISR signature of all accepted po words.

Function
REQ-020 The FSM SHALL have states IDLE, DRIVE and DONE.
REQ-021 In IDLE, start=1 SHALL clear pi, mismatch_cnt and first_fail_* to 0, set signature to all-ones, and enter DRIVE on the next edge.
REQ-022 busy SHALL be 1 exactly in DRIVE, and exp_ready SHALL equal busy.
REQ-023 A handshake (exp_valid & exp_ready) SHALL compare po with exp_data, update the counters and signature, and increment pi on the same edge.
REQ-024 Without a handshake, pi and all results SHALL hold, so backpressure stalls the sweep with no vector skipped.
REQ-025 On a mismatch, mismatch_cnt SHALL increment; if first_fail_valid=0, first_fail_vec SHALL capture pi and first_fail_valid SHALL be set.
REQ-026 The signature SHALL use a CRC-16-CCITT polynomial (0x1021) and absorb po bit 0 first, with one shift per bit: fb = sig[MSB]^bit; sig = (sig<<1) ^ (fb ? 0x1021 : 0).
REQ-027 A handshake with pi = all-ones SHALL enter DONE; pi SHALL wrap to 0, and no further vectors SHALL be accepted.
REQ-028 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-029 Results SHALL hold in IDLE until the next start.
REQ-030 With continuous exp_valid and start accepted at edge 0, DRIVE SHALL span cycles 1..2^N_IN, and done SHALL be high in cycle 2^N_IN+1.
REQ-031 abort SHALL have priority over a handshake in the same cycle.
REQ-032 abort in DRIVE SHALL return the FSM to IDLE next edge with no done pulse, and results SHALL freeze at their pre-abort values.
REQ-033 start in DRIVE or DONE SHALL be ignored.
REQ-034 mismatch_cnt SHALL reach 2^N_IN without overflow.

Reset
REQ-035 rst SHALL force IDLE and set pi, mismatch_cnt, first_fail_vec, first_fail_valid, busy, done and exp_ready to 0 and signature to all-ones, asynchronously, including mid-sweep.
REQ-036 After rst deasserts, the block SHALL stay in IDLE until a start is sampled.

Structure
REQ-037 A shared package SHALL hold the FSM state enum, the CRC polynomial constant and the signature init constant.
REQ-038 The MISR step SHALL be a sub-module misr_step, combinational with N_OUT input bits, instantiated once.

Verification
REQ-039 Reset mid-run: rst at vector 500 -> all outputs at reset values, busy=0, no done pulse.
REQ-040 Clean sweep: stub circuit po={pi[3]^pi[7], pi[0]&pi[10]}, matching golden, exp_valid=1 -> done in cycle 2049, mismatch_cnt=0, first_fail_valid=0, signature equals the bench model.
REQ-041 Fault injection: golden corrupted at vectors 0x155 and 0x6A0 -> mismatch_cnt=2, first_fail_vec=0x155.
REQ-042 Backpressure: exp_valid pseudo-random at 50% -> 2048 handshakes, pi monotonic with no gaps, signature identical to REQ-040.
REQ-043 Abort: abort together with a handshake at pi=100 -> IDLE next cycle, no done pulse, mismatch_cnt counts only vectors 0..99.
REQ-044 Start during busy: start pulses at vectors 10 and 2047 -> ignored, single done pulse, results identical to REQ-040.
